// File: rtl/tm_pkg.sv
// Shared constants and types for the template match scorer.
// Optional ink statistics are enabled with the TM_INK_HITS_EN macro.
package tm_pkg;
   localparam int   ADDR_W_DEF    = 12;
   localparam int   PIX_CNT       = 4096;
   localparam logic INK_LEVEL_DEF = 1'b0;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SCAN  = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } tm_state_e;

   typedef logic [ADDR_W_DEF:0] score_t;
endpackage

// File: rtl/tm_scan_ctrl.sv
// Scan sequencer: walks every address once, tags issued reads through a
// read-latency pipe and signals when the final read result lands.
//
// state | meaning
// IDLE  | waiting for start, score holds last result
// SCAN  | issuing addresses 0 .. 2**ADDR_W-1, one per clock
// DRAIN | no more issues, waiting for in-flight reads to return
// DONE  | one-cycle done pulse, score freshly loaded
module tm_scan_ctrl
   import tm_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int RD_LAT = 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   output logic              mem_ce,
   output logic [ADDR_W-1:0] mem_ad,
   output logic              tag_exit,
   output logic              clear_acc,
   output logic              load_score,
   output logic              busy,
   output logic              done
);
   localparam logic [ADDR_W-1:0] LAST_AD  = {ADDR_W{1'b1}};
   localparam logic [RD_LAT:0]   LAST_TAG = {1'b1, {RD_LAT{1'b0}}};

   tm_state_e         state_q, state_d;
   logic [ADDR_W-1:0] ad_q, ad_d;
   logic              ce_q, ce_d;
   logic [RD_LAT:0]   vld_q, vld_d;
   logic              rst_ok_q;

   // rst_ok_q keeps the first edge after reset release free of any action
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rst_ok_q <= 1'b0;
         state_q  <= IDLE;
         ad_q     <= '0;
         ce_q     <= 1'b0;
         vld_q    <= '0;
      end else begin
         rst_ok_q <= 1'b1;
         state_q  <= state_d;
         ad_q     <= ad_d;
         ce_q     <= ce_d;
         vld_q    <= vld_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      ad_d       = ad_q;
      ce_d       = ce_q;
      clear_acc  = 1'b0;
      load_score = 1'b0;
      case (state_q)
         IDLE: begin
            if (start && rst_ok_q) begin
               state_d   = SCAN;
               ad_d      = '0;
               ce_d      = 1'b1;
               clear_acc = 1'b1;
            end
         end
         SCAN: begin
            if (ad_q == LAST_AD) begin
               state_d = DRAIN;
               ad_d    = '0;
               ce_d    = 1'b0;
            end else begin
               ad_d = ad_q + 1'b1;
            end
         end
         DRAIN: begin
            // only the last tag remains and it exits this cycle
            if (vld_q == LAST_TAG) begin
               state_d    = DONE;
               load_score = 1'b1;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
      vld_d = {vld_q[RD_LAT-1:0], ce_d};
   end

   assign mem_ce   = ce_q;
   assign mem_ad   = ad_q;
   assign tag_exit = vld_q[RD_LAT];
   assign busy     = (state_q == SCAN) || (state_q == DRAIN);
   assign done     = (state_q == DONE);
endmodule

// File: rtl/template_match_score.sv
// Template match scorer: counts pixels where template ROM and image agree.
// Define TM_INK_HITS_EN to add ink_total / ink_hits statistics outputs.
module template_match_score
   import tm_pkg::*;
#(
   parameter int   ADDR_W    = ADDR_W_DEF,
   parameter int   RD_LAT    = 1
`ifdef TM_INK_HITS_EN
   , parameter logic INK_LEVEL = INK_LEVEL_DEF
`endif
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   output logic              mem_ce,
   output logic [ADDR_W-1:0] mem_ad,
   input  logic              rom_dout,
   input  logic              img_bit,
   output logic              busy,
   output logic              done,
   output logic [ADDR_W:0]   score
`ifdef TM_INK_HITS_EN
   , output logic [ADDR_W:0] ink_hits,
   output logic [ADDR_W:0]   ink_total
`endif
);
   logic            tag_exit, clear_acc, load_score, hit;
   logic [ADDR_W:0] acc_q, acc_d, score_q, score_d;

   tm_scan_ctrl #(.ADDR_W(ADDR_W), .RD_LAT(RD_LAT)) u_ctrl (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start),
      .mem_ce     (mem_ce),
      .mem_ad     (mem_ad),
      .tag_exit   (tag_exit),
      .clear_acc  (clear_acc),
      .load_score (load_score),
      .busy       (busy),
      .done       (done)
   );

   // memory data is only looked at while a tag exits, so X elsewhere is masked
   assign hit = tag_exit && (rom_dout == img_bit);

   always_comb begin
      acc_d   = clear_acc ? '0 : acc_q + {{ADDR_W{1'b0}}, hit};
      score_d = load_score ? acc_q + {{ADDR_W{1'b0}}, hit} : score_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc_q   <= '0;
         score_q <= '0;
      end else begin
         acc_q   <= acc_d;
         score_q <= score_d;
      end
   end

   assign score = score_q;

`ifdef TM_INK_HITS_EN
   logic            ink_t, ink_h;
   logic [ADDR_W:0] it_acc_q, it_acc_d, ih_acc_q, ih_acc_d;
   logic [ADDR_W:0] ink_total_q, ink_total_d, ink_hits_q, ink_hits_d;

   assign ink_t = tag_exit && (rom_dout == INK_LEVEL);
   assign ink_h = ink_t && (img_bit == INK_LEVEL);

   always_comb begin
      it_acc_d    = clear_acc ? '0 : it_acc_q + {{ADDR_W{1'b0}}, ink_t};
      ih_acc_d    = clear_acc ? '0 : ih_acc_q + {{ADDR_W{1'b0}}, ink_h};
      ink_total_d = load_score ? it_acc_q + {{ADDR_W{1'b0}}, ink_t} : ink_total_q;
      ink_hits_d  = load_score ? ih_acc_q + {{ADDR_W{1'b0}}, ink_h} : ink_hits_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         it_acc_q    <= '0;
         ih_acc_q    <= '0;
         ink_total_q <= '0;
         ink_hits_q  <= '0;
      end else begin
         it_acc_q    <= it_acc_d;
         ih_acc_q    <= ih_acc_d;
         ink_total_q <= ink_total_d;
         ink_hits_q  <= ink_hits_d;
      end
   end

   assign ink_total = ink_total_q;
   assign ink_hits  = ink_hits_q;
`endif
endmodule

// File: doc/template_match_score.md
Name: template_match_score

Overview:
- Downstream consumer of the 1-bit 4096-deep digit template ROMs (64x64 bitmap, 1 = background, 0 = ink).
- Scans every template address once per request and reads the binarized captured image bit at the same address from the 1-bit frame buffer.
- Counts pixel agreements and outputs a 13-bit similarity score.
- The digit classifier instantiates one per template ROM and picks the highest score.

Parameters:
ADDR_W, 12, template/image address width; pixel count = 2**ADDR_W
RD_LAT, 1, read latency in clocks of both memories (ROM with READ_MODE bypass = 1)
INK_LEVEL, 0, bit value meaning ink (used only by optional feature)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
start  in  1  single-cycle request to score the current frame
mem_ce  out  1  clock enable to template ROM and image buffer read port
mem_ad  out  ADDR_W  shared read address to ROM (ad) and image buffer
rom_dout  in  1  template bit, valid RD_LAT cycles after mem_ad/mem_ce are sampled
img_bit  in  1  image bit, same timing as rom_dout
busy  out  1  high from accepted start until done
done  out  1  one-cycle pulse, score valid from this cycle
score  out  ADDR_W+1  matching-pixel count, 0..4096

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, mem_ce=0, mem_ad=0, busy=0, done=0, score=0, accumulator=0, valid pipe=0.
  - Deassertion is synchronized internally; no action on the first edge after release.
- States: IDLE, SCAN, DRAIN, DONE.
- IDLE:
  - start=1 at edge E0 -> SCAN; accumulator cleared to 0; mem_ad=0; mem_ce=1; busy=1.
  - score keeps its previous value until the new result lands.
- SCAN:
  - mem_ad increments by 1 per clock; mem_ce=1 continuously.
  - The cycle presenting 2**ADDR_W-1 is the last; next state DRAIN; mem_ce=0; mem_ad returns to 0 (no wrap re-read).
- Valid pipeline:
  - A 1-bit shift register of depth RD_LAT+1 tags each issued address.
  - When the tag exits, the accumulator adds (rom_dout == img_bit).
  - Sampling of rom_dout/img_bit happens at issue edge + RD_LAT + 1.
- DRAIN: waits until the pipeline is empty (RD_LAT+1 edges after the last issue), then DONE.
- DONE:
  - The final accumulate and the score register load happen on the same edge.
  - done=1 and busy=0 for exactly one cycle; next state IDLE.
  - With RD_LAT=1, done is high in the cycle after edge E0+4097.
- Accumulator width ADDR_W+1; max 4096 fits without saturation; no overflow possible.
- start while busy=1 (SCAN/DRAIN/DONE) is ignored; not queued.
- start in the same cycle done is high is ignored; a new start is accepted only in IDLE.
- rst_n asserted mid-scan:
  - Immediate abort; all outputs return to reset values; no done pulse.
  - Partial count is discarded.
- rom_dout/img_bit are ignored whenever no tag exits the pipeline; X on them outside valid slots must not propagate.

Optional Feature:
- Macro: TM_INK_HITS_EN.
- Defined:
  - Extra outputs ink_hits (ADDR_W+1) and ink_total (ADDR_W+1).
  - ink_total counts template bits == INK_LEVEL.
  - ink_hits counts positions where both template and image == INK_LEVEL.
  - Both update, clear and reset exactly like score and are valid at done.
- Undefined: ports and counters absent; score behaviour identical.

Decomposition:
- Package tm_pkg:
  - ADDR_W default constant.
  - PIX_CNT = 4096.
  - State encoding enum {IDLE, SCAN, DRAIN, DONE} as 2-bit typedef.
  - INK_LEVEL constant.
  - score_t typedef (ADDR_W+1 bits).
- One natural sub-module: tm_scan_ctrl (state machine, address counter, valid shift register, busy/done).
- The top holds the comparator and accumulators.

Test Plan:
- ROM model all 1s, image all 1s, start pulse -> done at E0+4097, score=4096, busy high E0+1..E0+4097.
- ROM all 1s, image all 0s -> score=0; with TM_INK_HITS_EN and INK_LEVEL=0: ink_total=0, ink_hits=0.
- ROM all 1s, image checkerboard (bit = ad[0]^ad[6]) -> score=2048.
- Second start pulse at E0+100 during SCAN -> ignored; single done; score unchanged vs. the single-start run.
- rst_n low at E0+2000 for 3 cycles -> all outputs 0, no done pulse. Then a fresh start with ROM digit-2 template and identical image -> score=4096.
- Image = template with exactly 37 bits flipped, RD_LAT=2 model -> score=4059, done at E0+4098.
